// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen_if
// Brief    : Raster timing / pixel request bundle between the timing generator
//            and the pixel-colour stage.
// Revision : 1.0 - initial release
// ============================================================================
interface video_timing_gen_if;
  logic [23:0] pixel_data;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic        data_req;
  logic        video_hs;
  logic        video_vs;
  logic        video_de;
  logic [23:0] video_rgb;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    input  pixel_data,
    output pixel_xpos, pixel_ypos, data_req,
    output video_hs, video_vs, video_de, video_rgb,
    output frame_start, frame_cnt
  );

  modport slave (
    output pixel_data,
    input  pixel_xpos, pixel_ypos, data_req,
    input  video_hs, video_vs, video_de, video_rgb,
    input  frame_start, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Brief    : 1280x720@60 raster timing generator with one-clock-early pixel
//            request, colour mux and frame strobes.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
  parameter int H_SYNC   = 40,
  parameter int H_BACK   = 220,
  parameter int H_DISP   = 1280,
  parameter int H_FRONT  = 110,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 20,
  parameter int V_DISP   = 720,
  parameter int V_FRONT  = 5,
  parameter bit SYNC_POL = 1'b1
) (
  input  wire logic            pixel_clk,
  input  wire logic            sys_rst_n,
  video_timing_gen_if.master   vif
);

  // 12-bit counters cover line/frame totals up to 4096.
  localparam logic [11:0] c_h_last    = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [11:0] c_h_sync    = 12'(H_SYNC);
  localparam logic [11:0] c_ha0       = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] c_ha0_m1    = 12'(H_SYNC + H_BACK - 1);
  localparam logic [11:0] c_h_de_end  = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] c_h_req_end = 12'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [11:0] c_v_last    = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [11:0] c_v_sync    = 12'(V_SYNC);
  localparam logic [11:0] c_va0       = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] c_v_de_end  = 12'(V_SYNC + V_BACK + V_DISP);

  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic        r_req;
  logic [10:0] r_xpos;
  logic [10:0] r_ypos;
  logic        r_fs;
  logic [15:0] r_fcnt;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_v_act;
  logic        w_de;
  logic        w_req;
  logic        w_fs;
  logic [11:0] w_xdiff;
  logic [11:0] w_ydiff;

  assign w_h_last = (r_h_cnt == c_h_last);
  assign w_v_last = (r_v_cnt == c_v_last);
  assign w_v_act  = (r_v_cnt >= c_va0) && (r_v_cnt < c_v_de_end);
  assign w_de     = w_v_act && (r_h_cnt >= c_ha0) && (r_h_cnt < c_h_de_end);
  // Request window is the DE window shifted one clock earlier.
  assign w_req    = w_v_act && (r_h_cnt >= c_ha0_m1) && (r_h_cnt < c_h_req_end);
  assign w_fs     = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
  assign w_xdiff  = r_h_cnt - c_ha0_m1;
  assign w_ydiff  = r_v_cnt - c_va0;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hs    <= ~SYNC_POL;
      r_vs    <= ~SYNC_POL;
      r_de    <= 1'b0;
      r_req   <= 1'b0;
      r_xpos  <= '0;
      r_ypos  <= '0;
      r_fs    <= 1'b0;
      r_fcnt  <= '0;
    end else begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? 12'd0 : r_v_cnt + 12'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 12'd1;
      end
      r_hs   <= (r_h_cnt < c_h_sync) ? SYNC_POL : ~SYNC_POL;
      r_vs   <= (r_v_cnt < c_v_sync) ? SYNC_POL : ~SYNC_POL;
      r_de   <= w_de;
      r_req  <= w_req;
      // Blanking positions are forced to 0 so they never reach the renderer.
      r_xpos <= w_req ? w_xdiff[10:0] : 11'd0;
      r_ypos <= w_req ? w_ydiff[10:0] : 11'd0;
      r_fs   <= w_fs;
      if (w_fs) begin
        r_fcnt <= r_fcnt + 16'd1;
      end
    end
  end

  assign vif.video_hs    = r_hs;
  assign vif.video_vs    = r_vs;
  assign vif.video_de    = r_de;
  assign vif.data_req    = r_req;
  assign vif.pixel_xpos  = r_xpos;
  assign vif.pixel_ypos  = r_ypos;
  assign vif.frame_start = r_fs;
  assign vif.frame_cnt   = r_fcnt;
  assign vif.video_rgb   = r_de ? vif.pixel_data : 24'h000000;

endmodule
`default_nettype wire
